psum_bram_arbiter: RTL and testbench

//  Shares one output-BRAM port among NUM_REQ partial-sum requesters (accumulator lanes, host readback).

---
 rtl/psum_arb_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/psum_bram_arbiter.sv | 148 ++++++++++++++
 tb/tb_psum_bram_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_arb_pkg.sv
// Shared types and helpers for the partial-sum BRAM arbiter.
package psum_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_REL   = 2'd2
  } arb_state_t;

  localparam int OWNER_BIT = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping to index 0.
module rr_priority_picker
  import psum_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]         req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [N-1:0]         pick,
  output logic [OWNER_BIT-1:0] idx,
  output logic                 valid
);

  logic [N-1:0] upper;
  logic [N-1:0] sel;

  // Prefer requests at or above the pointer; fall back to the lowest request to wrap around.
  always_comb begin
    upper = '0;
    pick  = '0;
    idx   = '0;
    valid = |req;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    sel = (|upper) ? upper : req;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        idx     = OWNER_BIT'(i);
      end
    end
  end

endmodule

// File: rtl/psum_bram_arbiter.sv
// Round-robin arbiter sharing one output-BRAM port; each grant covers a whole read-modify-write.
// Optional hold watchdog enabled by defining PSUM_ARB_WDOG_EN.
module psum_bram_arbiter
  import psum_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BRAM_WIDTH    = 32,
  parameter int BRAM_ADDR_BIT = 32,
  parameter int BRAM_BYTE     = BRAM_WIDTH / 8,
  parameter int MAX_HOLD      = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  output logic [NUM_REQ-1:0]                 gnt,
  input  logic [NUM_REQ*BRAM_ADDR_BIT-1:0]   req_addr,
  input  logic [NUM_REQ*BRAM_WIDTH-1:0]      req_din,
  input  logic [NUM_REQ*BRAM_BYTE-1:0]       req_wen,
  output logic [BRAM_WIDTH-1:0]              rdata,
  output logic [OWNER_BIT-1:0]               owner,
  output logic                               busy,
  output logic                               wdog_err,
  output logic [BRAM_ADDR_BIT-1:0]           BRAM_addr,
  output logic                               BRAM_clk,
  output logic [BRAM_WIDTH-1:0]              BRAM_din,
  input  logic [BRAM_WIDTH-1:0]              BRAM_dout,
  output logic                               BRAM_en,
  output logic                               BRAM_rst,
  output logic [BRAM_BYTE-1:0]               BRAM_wen
);

  localparam int PTR_W = clog2(NUM_REQ);

  arb_state_t               state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         next_ptr;
  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       pick;
  logic [OWNER_BIT-1:0]     pick_idx;
  logic                     pick_valid;
  logic [BRAM_ADDR_BIT-1:0] mux_addr;
  logic [BRAM_ADDR_BIT-1:0] last_addr;
  logic [BRAM_WIDTH-1:0]    mux_din;
  logic [BRAM_WIDTH-1:0]    last_din;
  logic [BRAM_BYTE-1:0]     mux_wen;
  logic                     owner_req;
  logic                     revoke;

  rr_priority_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    mux_addr  = '0;
    mux_din   = '0;
    mux_wen   = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWNER_BIT'(i)) begin
        mux_addr  = req_addr[i*BRAM_ADDR_BIT +: BRAM_ADDR_BIT];
        mux_din   = req_din[i*BRAM_WIDTH +: BRAM_WIDTH];
        mux_wen   = req_wen[i*BRAM_BYTE +: BRAM_BYTE];
        owner_req = req[i];
      end
    end
  end

  assign next_ptr  = (owner == OWNER_BIT'(NUM_REQ - 1)) ? '0 : PTR_W'(owner + 3'd1);
  assign BRAM_addr = busy ? mux_addr : last_addr;
  assign BRAM_din  = busy ? mux_din : last_din;
  assign BRAM_wen  = busy ? mux_wen : '0;
  assign BRAM_clk  = clk;
  assign BRAM_en   = 1'b1;
  assign BRAM_rst  = 1'b0;
  assign rdata     = BRAM_dout;

`ifdef PSUM_ARB_WDOG_EN
  localparam int HOLD_W = clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0]  hold_cnt;
  logic [NUM_REQ-1:0] blocked;
  logic               wdog_q;

  assign revoke   = (state == ST_GRANT) && owner_req && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign eligible = req & ~blocked;
  assign wdog_err = wdog_q;

  // A revoked owner stays locked out until it lowers its request for at least one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      blocked  <= '0;
      wdog_q   <= 1'b0;
    end else begin
      blocked  <= (blocked & req) | (revoke ? gnt : '0);
      hold_cnt <= (state == ST_GRANT) ? hold_cnt + 1'b1 : '0;
      if (revoke) wdog_q <= 1'b1;
    end
  end
`else
  assign revoke   = 1'b0;
  assign eligible = req;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      last_addr <= '0;
      last_din  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt   <= pick;
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          last_addr <= mux_addr;
          last_din  <= mux_din;
          if (!owner_req || revoke) begin
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= ST_REL;
          end
        end
        ST_REL:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_bram_arbiter.sv
// Self-checking bench for psum_bram_arbiter with a cycle-level reference model and a small BRAM.
module tb_psum_bram_arbiter;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int AW  = 32;
  localparam int BB  = 4;
  localparam int MH  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   gnt;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*W-1:0]  req_din  = '0;
  logic [NR*BB-1:0] req_wen  = '0;
  logic [W-1:0]    rdata;
  logic [2:0]      owner;
  logic            busy;
  logic            wdog_err;
  logic [AW-1:0]   BRAM_addr;
  logic            BRAM_clk;
  logic [W-1:0]    BRAM_din;
  logic [W-1:0]    BRAM_dout;
  logic            BRAM_en;
  logic            BRAM_rst;
  logic [BB-1:0]   BRAM_wen;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  psum_bram_arbiter #(
    .NUM_REQ       (NR),
    .BRAM_WIDTH    (W),
    .BRAM_ADDR_BIT (AW),
    .BRAM_BYTE     (BB),
    .MAX_HOLD      (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .req_addr  (req_addr),
    .req_din   (req_din),
    .req_wen   (req_wen),
    .rdata     (rdata),
    .owner     (owner),
    .busy      (busy),
    .wdog_err  (wdog_err),
    .BRAM_addr (BRAM_addr),
    .BRAM_clk  (BRAM_clk),
    .BRAM_din  (BRAM_din),
    .BRAM_dout (BRAM_dout),
    .BRAM_en   (BRAM_en),
    .BRAM_rst  (BRAM_rst),
    .BRAM_wen  (BRAM_wen)
  );

  always #5 clk = ~clk;

  // Small BRAM with one-cycle read latency and a bench-side preload path.
  logic [W-1:0] mem [0:15];
  logic         load_en   = 1'b0;
  logic [3:0]   load_addr = '0;
  logic [W-1:0] load_val  = '0;

  always @(posedge BRAM_clk) begin
    if (load_en) begin
      mem[load_addr] <= load_val;
    end else if (BRAM_en) begin
      for (int b = 0; b < BB; b++)
        if (BRAM_wen[b]) mem[BRAM_addr[3:0]][b*8 +: 8] <= BRAM_din[b*8 +: 8];
    end
    BRAM_dout <= mem[BRAM_addr[3:0]];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [AW-1:0] addrOf(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [W-1:0] dinOf(input int i);
    return req_din[i*W +: W];
  endfunction

  function automatic logic [BB-1:0] wenOf(input int i);
    return req_wen[i*BB +: BB];
  endfunction

  function automatic int onehotIdx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: who owns the port, how many quiet cycles remain, and whose turn is next.
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_hold  = 0;
  bit            m_turn  = 1'b0;
  bit            m_err   = 1'b0;
  logic [NR-1:0] m_blocked = '0;
  logic [AW-1:0] m_last_addr = '0;
  logic [W-1:0]  m_last_din  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_turn = 1'b0; m_err = 1'b0;
      m_blocked = '0; m_last_addr = '0; m_last_din = '0;
    end else begin
      bit rel;
      bit wd;
      m_blocked = m_blocked & req;
      if (m_owner >= 0) begin
        m_last_addr = addrOf(m_owner);
        m_last_din  = dinOf(m_owner);
        rel = !req[m_owner];
        wd  = 1'b0;
`ifdef PSUM_ARB_WDOG_EN
        if (!rel && m_hold == MH - 1) begin rel = 1'b1; wd = 1'b1; end
`endif
        if (rel) begin
          m_ptr = (m_owner + 1) % NR;
          if (wd) begin m_err = 1'b1; m_blocked[m_owner] = 1'b1; end
          m_owner = -1;
          m_turn  = 1'b1;
        end else begin
          m_hold++;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
      end else begin
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (m_ptr + k) % NR;
          if (m_owner < 0 && req[c] && !m_blocked[c]) begin
            m_owner = c;
            m_hold  = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NR-1:0] eg;
      bit eb;
      eb = (m_owner >= 0);
      eg = '0;
      if (eb) eg[m_owner] = 1'b1;
      checkOutput("gnt", gnt, eg);
      checkOutput("busy", busy, eb);
      if (eb) checkOutput("owner", owner, m_owner);
      checkOutput("bram_addr", BRAM_addr, eb ? addrOf(m_owner) : m_last_addr);
      checkOutput("bram_din", BRAM_din, eb ? dinOf(m_owner) : m_last_din);
      checkOutput("bram_wen", BRAM_wen, eb ? wenOf(m_owner) : '0);
      checkOutput("wdog_err", wdog_err, m_err);
      checkOutput("rdata", rdata, BRAM_dout);
      checkOutput("bram_en_rst", {BRAM_en, BRAM_rst}, 2'b10);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r);
    req = r;
    stepCycle();
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = '0;
    req_wen = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic setLane(input int i, input logic [AW-1:0] a, input logic [W-1:0] d, input logic [BB-1:0] e);
    req_addr[i*AW +: AW] = a;
    req_din[i*W +: W]    = d;
    req_wen[i*BB +: BB]  = e;
  endtask

  int grant_order [8];
  int grant_cnt;

  // Raises the masked requests; each owner holds for 'hold' cycles, then drops and optionally re-raises.
  task automatic runGrants(input logic [NR-1:0] mask, input int ngrants, input int hold, input bit persist);
    int held, cyc, cur;
    logic [NR-1:0] reraise, prev;
    grant_cnt = 0; held = 0; cur = -1; cyc = 0;
    reraise = '0; prev = gnt;
    req = mask;
    while (grant_cnt < ngrants && cyc < 200) begin
      stepCycle();
      cyc++;
      req = req | reraise;
      reraise = '0;
      if (gnt != '0 && prev == '0) begin
        cur = onehotIdx(gnt);
        grant_order[grant_cnt] = cur;
        grant_cnt++;
        held = 0;
      end
      prev = gnt;
      if (cur >= 0 && grant_cnt < ngrants) begin
        held++;
        if (held == hold) begin
          req[cur] = 1'b0;
          if (persist) reraise[cur] = 1'b1;
          cur = -1;
        end
      end
    end
    if (grant_cnt < ngrants) checkOutput("grant_timeout", grant_cnt, ngrants);
  endtask

  task automatic rmwLane(input int lane, input logic [7:0] inc);
    int waited;
    logic [W-1:0] rd;
    setLane(lane, 32'd3, 32'd0, 4'b0000);
    req[lane] = 1'b1;
    waited = 0;
    while (!gnt[lane] && waited < 40) begin
      stepCycle();
      waited++;
    end
    if (!gnt[lane]) begin
      checkOutput("rmw_grant_timeout", waited, 0);
      req[lane] = 1'b0;
    end else begin
      stepCycle();
      rd = rdata;
      setLane(lane, 32'd3, {rd[31:8], rd[7:0] + inc}, 4'b0001);
      stepCycle();
      req_wen[lane*BB +: BB] = '0;
      req[lane] = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    doReset();
    chk_en = 1'b1;

    // 1: single requester, reset values, 1-cycle grant latency, REL turnaround
    checkOutput("t1_reset_gnt", gnt, 4'b0000);
    checkOutput("t1_reset_busy", busy, 1'b0);
    checkOutput("t1_reset_addr", BRAM_addr, 32'h0);
    checkOutput("t1_reset_wen", BRAM_wen, 4'b0000);
    setLane(0, 32'h100, 32'hA5A5_0001, 4'b0011);
    applyStimulus(4'b0001);
    checkOutput("t1_gnt", gnt, 4'b0001);
    checkOutput("t1_addr", BRAM_addr, 32'h100);
    checkOutput("t1_wen", BRAM_wen, 4'b0011);
    stepCycle();
    stepCycle();
    applyStimulus(4'b0000);
    checkOutput("t1_rel_gnt", gnt, 4'b0000);
    checkOutput("t1_rel_wen", BRAM_wen, 4'b0000);
    checkOutput("t1_rel_addr_hold", BRAM_addr, 32'h100);
    stepCycle();
    checkOutput("t1_idle_busy", busy, 1'b0);

    // 2: all four requesting, grant order 0,1,2,3,0
    doReset();
    for (int i = 0; i < NR; i++)
      setLane(i, 32'h200 + i, 32'h1000 + i, 4'(1 << i));
    runGrants(4'b1111, 5, 3, 1'b1);
    req = '0;
    repeat (4) stepCycle();
    checkOutput("t2_order0", grant_order[0], 0);
    checkOutput("t2_order1", grant_order[1], 1);
    checkOutput("t2_order2", grant_order[2], 2);
    checkOutput("t2_order3", grant_order[3], 3);
    checkOutput("t2_order4", grant_order[4], 0);

    // 3: pointer moved to 2 by a requester-1 transaction, then 0 and 1 wrap around
    doReset();
    runGrants(4'b0010, 1, 2, 1'b0);
    req = '0;
    repeat (4) stepCycle();
    runGrants(4'b0011, 2, 2, 1'b0);
    req = '0;
    repeat (4) stepCycle();
    checkOutput("t3_first", grant_order[0], 0);
    checkOutput("t3_second", grant_order[1], 1);

    // 4: asynchronous reset in the middle of a write grant
    doReset();
    setLane(2, 32'h40, 32'hDEAD_BEEF, 4'b0001);
    applyStimulus(4'b0100);
    checkOutput("t4_gnt_before", gnt, 4'b0100);
    checkOutput("t4_wen_before", BRAM_wen, 4'b0001);
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_async_wen", BRAM_wen, 4'b0000);
    checkOutput("t4_async_gnt", gnt, 4'b0000);
    checkOutput("t4_async_busy", busy, 1'b0);
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    stepCycle();
    checkOutput("t4_idle_busy", busy, 1'b0);

    // 5: two lanes read-modify-write the same byte
    doReset();
    load_en = 1'b1; load_addr = 4'd3; load_val = 32'd5;
    stepCycle();
    load_en = 1'b0;
    fork
      rmwLane(0, 8'd1);
      rmwLane(1, 8'd2);
    join
    repeat (3) stepCycle();
    checkOutput("t5_rmw_byte", mem[3], 32'd8);

    // 6: long hold; revoked at MAX_HOLD with the watchdog, unlimited otherwise
    doReset();
    setLane(0, 32'h300, 32'h55, 4'b0001);
    req = 4'b0001;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt[0]) cnt++;
    end
    #1;
`ifdef PSUM_ARB_WDOG_EN
    checkOutput("t6_hold_cycles", cnt, 8);
    checkOutput("t6_wdog", wdog_err, 1'b1);
`else
    checkOutput("t6_hold_cycles", cnt, 19);
    checkOutput("t6_wdog", wdog_err, 1'b0);
`endif
    @(posedge clk);
    #1 req = '0;
    repeat (3) stepCycle();
`ifdef PSUM_ARB_WDOG_EN
    checkOutput("t6_wdog_sticky", wdog_err, 1'b1);
`else
    checkOutput("t6_wdog_sticky", wdog_err, 1'b0);
`endif
    doReset();
    checkOutput("t6_wdog_cleared", wdog_err, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
